// File: rtl/bcd_alu_host_pkg.sv
// Shared constants and types for the BCD ALU serial host.
package bcd_alu_host_pkg;

  localparam logic [7:0] CMD_HDR     = 8'h5A;
  localparam logic [7:0] RSP_HDR     = 8'h96;
  localparam int         CMD_FRAME_W = 41;  // header + op + a + b
  localparam int         RSP_FRAME_W = 28;  // header + 5 result digits
  localparam int         RSP_DATA_W  = RSP_FRAME_W - 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    HUNT,
    CAPTURE,
    RESP
  } state_t;

  // Command frame as it goes on the wire, MSB first.
  function automatic logic [CMD_FRAME_W-1:0] build_frame(
    input logic        op,
    input logic [15:0] a,
    input logic [15:0] b
  );
    return {CMD_HDR, op, a, b};
  endfunction

endpackage

// File: rtl/bcd_frame_shifter.sv
// Parallel-load serializer: presents the frame MSB first, one bit per shift.
module bcd_frame_shifter
  import bcd_alu_host_pkg::*;
#(
  parameter int W = CMD_FRAME_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] frame,
  input  logic         shift,
  output logic         bit_out,
  output logic         done
);

  logic [W-1:0] sr;
  logic [5:0]   cnt;

  localparam logic [5:0] LAST = 6'(W - 1);

  // Load the frame, then shift left once per enabled cycle; counter stops at the last bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= frame;
      cnt <= '0;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
      if (cnt != LAST) cnt <= cnt + 6'd1;
    end
  end

  assign bit_out = sr[W-1];
  // High while the final bit of the frame is on bit_out.
  assign done    = (cnt == LAST);

endmodule

// File: rtl/bcd_alu_host.sv
// Host side of a serial BCD ALU: sends one command frame, hunts for the
// response header, captures 5 result digits and hands them out.
module bcd_alu_host
  import bcd_alu_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [15:0]           cmd_a,
  input  logic [15:0]           cmd_b,
  output logic                  dout,
  input  logic                  din,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RSP_DATA_W-1:0] rsp_data,
  output logic                  rsp_timeout
);

  localparam int               TCW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0]   TMAX     = TCW'(TIMEOUT_CYCLES);
  localparam logic [5:0]       CAP_LAST = 6'(RSP_DATA_W - 1);

  state_t         state, state_nxt;
  logic [7:0]     win, win_nxt;
  logic [TCW-1:0] tcnt, tcnt_inc;
  logic [5:0]     cap_cnt;
  logic           load, shift, sh_bit, sh_done;
  logic           hdr_hit, to_hit;

  bcd_frame_shifter #(.W(CMD_FRAME_W)) u_shifter (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .frame   (build_frame(cmd_op, cmd_a, cmd_b)),
    .shift   (shift),
    .bit_out (sh_bit),
    .done    (sh_done)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode. The header compare uses the window
  // including this cycle's din, so the match is fully sliding.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    win_nxt   = {win[6:0], din};
    tcnt_inc  = (tcnt == TMAX) ? tcnt : tcnt + 1'b1;
    hdr_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        shift = 1'b1;
        if (sh_done) state_nxt = HUNT;
      end
      HUNT: begin
        if (win_nxt == RSP_HDR) begin
          hdr_hit   = 1'b1;
          state_nxt = CAPTURE;
        end else if (tcnt_inc == TMAX) begin
          to_hit    = 1'b1;
          state_nxt = RESP;
        end
      end
      CAPTURE: begin
        if (cap_cnt == CAP_LAST) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hunt window, timeout counter, capture counter and response registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win         <= '0;
      tcnt        <= '0;
      cap_cnt     <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        SEND: begin
          if (sh_done) begin
            win  <= '0;
            tcnt <= '0;
          end
        end
        HUNT: begin
          win  <= win_nxt;
          tcnt <= tcnt_inc;
          if (hdr_hit) begin
            cap_cnt  <= '0;
            rsp_data <= '0;
          end else if (to_hit) begin
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
          end
        end
        CAPTURE: begin
          rsp_data <= {rsp_data[RSP_DATA_W-2:0], din};
          if (cap_cnt != CAP_LAST) cap_cnt <= cap_cnt + 6'd1;
        end
        RESP: begin
          if (rsp_ready) rsp_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign dout      = (state == SEND) & sh_bit;

endmodule

// File: tb/tb_bcd_alu_host.sv
// Scoreboard bench for bcd_alu_host with a bit-level ALU response model.
module tb_bcd_alu_host;

  localparam int TO = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_op = 1'b0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        din = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready, dout, rsp_valid, rsp_timeout;
  logic [19:0] rsp_data;

  bcd_alu_host #(.TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .dout        (dout),
    .din         (din),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        to;
    logic [19:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one command and collect nbits of dout, sampled on falling edges.
  task automatic send_cmd(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input int nbits, output logic [40:0] got);
    @(negedge clock);
    check("cmd_ready_before_send", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      got = {got[39:0], dout};
    end
  endtask

  // ALU model: drive a bit stream MSB first, one bit per cycle.
  task automatic stream(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clock);
      din = bits[i];
    end
    @(posedge clock);
    #1 din = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rsp_valid && n < 400);
    check("rsp_valid_seen", rsp_valid, 1'b1);
    check("dout_quiet_in_resp", dout, 1'b0);
  endtask

  // Pop the expected response, optionally hold off rsp_ready, then accept.
  task automatic take_rsp(input int hold);
    rsp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
      return;
    end
    e = exp_q.pop_front();
    check("rsp_data", rsp_data, e.data);
    check("rsp_timeout", rsp_timeout, e.to);
    if (hold > 0) cmd_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_data", rsp_data, e.data);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clock);
    check("rsp_valid_cleared", rsp_valid, 1'b0);
    check("cmd_ready_after_rsp", cmd_ready, 1'b1);
  endtask

  task automatic full_txn(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic [63:0] bits, input int n, input logic [19:0] res,
                          input int hold);
    logic [40:0] got;
    int lat;
    send_cmd(op, a, b, 41, got);
    check("frame", got, {8'h5A, op, a, b});
    exp_q.push_back('{to: 1'b0, data: res});
    stream(bits, n);
    wait_rsp(lat);
    take_rsp(hold);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [40:0] got;
    logic [40:0] f;
    logic        seen;
    int          lat;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_dout", dout, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 20'h0);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Add
    full_txn(1'b0, 16'h1234, 16'h5678, {8'h96, 20'h06912}, 28, 20'h06912, 0);
    // Subtract with response backpressure
    full_txn(1'b1, 16'h0100, 16'h0001, {8'h96, 20'h00099}, 28, 20'h00099, 10);
    // Misaligned header preceded by noise that contains partial matches
    full_txn(1'b0, 16'h0617, 16'h0617, {5'b10010, 8'h96, 20'h01234}, 33, 20'h01234, 0);

    // Timeout: din stays low throughout HUNT
    send_cmd(1'b1, 16'h4321, 16'h8765, 41, got);
    check("frame_to", got, {8'h5A, 1'b1, 16'h4321, 16'h8765});
    exp_q.push_back('{to: 1'b1, data: 20'h0});
    din = 1'b0;
    wait_rsp(lat);
    check("timeout_latency", lat, TO + 1);
    take_rsp(0);

    // Reset in the middle of SEND, at frame bit 20 (cmd_a[5] = 1)
    f = {8'h5A, 1'b0, 16'hFFFF, 16'h0000};
    send_cmd(1'b0, 16'hFFFF, 16'h0000, 20, got);
    check("partial_frame", got[19:0], f[40:21]);
    check("dout_bit20", dout, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_mid_dout", dout, 1'b0);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check("rst_mid_cmd_ready", cmd_ready, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (rsp_valid || dout) seen = 1'b1;
    end
    check("no_partial_rsp", seen, 1'b0);

    // Next command starts cleanly from the header bit
    full_txn(1'b0, 16'h9999, 16'h0001, {8'h96, 20'h10000}, 28, 20'h10000, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_alu_host.md
BCD_ALU_HOST -- requirements
Module: bcd_alu_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max HUNT cycles before the response is abandoned.
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-006 SHALL have port cmd_op  input  1  0 = BCD add, 1 = BCD subtract.
REQ-007 SHALL have port cmd_a  input  16  operand A, 4 BCD digits, digit 3 in [15:12].
REQ-008 SHALL have port cmd_b  input  16  operand B, same layout.
REQ-009 SHALL have port dout  output  1  serial command stream to the ALU serial input.
REQ-010 SHALL have port din  input  1  serial result stream from the ALU serial output.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-013 SHALL have port rsp_data  output  20  result digits {f4,f3,f2,f1,f0}, f4 in [19:16].
REQ-014 SHALL have port rsp_timeout  output  1  qualifies rsp_valid; no result header was found.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, HUNT, CAPTURE, RESP.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid & cmd_ready.
REQ-017 On accept, SHALL latch the 41-bit frame {8'h5A, cmd_op, cmd_a, cmd_b}, then go to SEND.
REQ-018 In SEND, dout SHALL present the frame MSB first, one bit per cycle: header bit 7 in cycle T+1 after accept at T, cmd_b[0] in cycle T+41.
REQ-019 dout SHALL be 0 in every state other than SEND.
REQ-020 After the 41st bit, SHALL enter HUNT with an 8-bit window cleared to 0 and the timeout counter cleared to 0.
REQ-021 In HUNT, SHALL shift din into the window LSB each cycle; a window equal to 8'h96 SHALL move the FSM to CAPTURE.
REQ-022 Header match SHALL be sliding, so no bit alignment is assumed, and overlapping partial matches SHALL NOT be lost.
REQ-023 In CAPTURE, SHALL shift exactly 20 din bits MSB first into rsp_data, then enter RESP.
REQ-024 If the timeout counter reaches TIMEOUT_CYCLES in HUNT, SHALL enter RESP with rsp_timeout=1 and rsp_data=0.
REQ-025 In RESP, rsp_valid SHALL be 1, and rsp_data/rsp_timeout SHALL hold stable until rsp_valid & rsp_ready, then the FSM SHALL return to IDLE.
REQ-026 A new command SHALL NOT be accepted in the RESP-to-IDLE transition cycle, so only one command is outstanding.
REQ-027 Operand digits SHALL be sent unchanged, without BCD range checking.
REQ-028 Bit counters SHALL be 6 bits wide and SHALL NOT wrap; the timeout counter SHALL saturate at TIMEOUT_CYCLES.

Reset
REQ-029 Asserting reset (low) SHALL immediately force IDLE, cmd_ready=1 after release, dout=0, rsp_valid=0, rsp_timeout=0, rsp_data=0, and all counters and the window to 0.
REQ-030 Reset mid-SEND, HUNT or CAPTURE SHALL abandon the transaction, with no partial response.

Structure
REQ-031 A shared package SHALL hold CMD_HDR=8'h5A, RSP_HDR=8'h96, the frame widths 41 and 28, and the FSM state enum.
REQ-032 The serializer SHALL be one sub-module, bcd_frame_shifter: parallel-load 41-bit shift register with a bit counter and a done flag.

Verification
REQ-033 Add: cmd_op=0, a=16'h1234, b=16'h5678 -> dout carries 5A,0,1234,5678; ALU model returns 96 then 06912 -> rsp_data=20'h06912, rsp_timeout=0.
REQ-034 Subtract: cmd_op=1, a=16'h0100, b=16'h0001 -> op bit = 1; response 96,00099 -> rsp_data=20'h00099.
REQ-035 Timeout: din held 0 after SEND -> rsp_valid rises after 255 HUNT cycles, rsp_timeout=1, rsp_data=0.
REQ-036 Misalignment: noise bits 1,0,0,1,0 precede 96,01234 -> rsp_data=20'h01234.
REQ-037 Backpressure: rsp_ready low for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout; accept clears rsp_valid next cycle.
REQ-038 Reset low at SEND bit 20 -> dout=0 immediately, no rsp_valid; after release the next command is sent from the header bit.
